// File: rtl/ccff_chain_loader_if.sv
// Bundles the bitstream-side handshake, the chain serial pins and the status/readback outputs.
// No logic and no latency; the signals pass straight between loader and its peers.
// word_valid/word_ready carry backpressure from loader to source; every other signal is unthrottled.
interface ccff_chain_loader_if #(
  parameter int WORD_W = 32
);
  logic              start;
  logic [WORD_W-1:0] word_in;
  logic              word_valid;
  logic              word_ready;
  logic              ccff_head;
  logic              chain_shift_en;
  logic              ccff_tail;
  logic              busy;
  logic              done;
  logic [WORD_W-1:0] readback_word;
  logic              readback_valid;

  // Bitstream source / tile side.
  modport master (
    output start, word_in, word_valid, ccff_tail,
    input  word_ready, ccff_head, chain_shift_en, busy, done, readback_word, readback_valid
  );

  // Loader side.
  modport slave (
    input  start, word_in, word_valid, ccff_tail,
    output word_ready, ccff_head, chain_shift_en, busy, done, readback_word, readback_valid
  );
endinterface

// File: rtl/ccff_chain_loader.sv
// Serialises configuration words LSB-first onto a CCFF chain and collects the bits leaving its tail.
// start->word_ready 1 cycle; accept->first chain bit 1 cycle; one FETCH cycle between words.
// Waits in FETCH with the chain frozen while word_valid is low; outputs are never backpressured.
module ccff_chain_loader #(
  parameter int WORD_W    = 32,
  parameter int CHAIN_LEN = 64
) (
  input logic                prog_clk,
  input logic                prog_reset_n,
  ccff_chain_loader_if.slave bus
);
  localparam int CNT_W  = $clog2(CHAIN_LEN + 1);
  localparam int WCNT_W = $clog2(WORD_W + 1);
  localparam int IDX_W  = $clog2(WORD_W);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;     // bits pushed into the chain so far
  logic [WCNT_W-1:0]   wcnt_q, wcnt_d;   // bits of the current word still to shift
  logic [IDX_W-1:0]    idx_q, idx_d;     // readback capture position
  logic [WORD_W-1:0]   sreg_q, sreg_d;
  logic [WORD_W-1:0]   rb_q, rb_d;
  logic                rbv_q, rbv_d;
  logic [31:0]         remaining;

  // State and datapath registers; reset leaves every output at 0 immediately.
  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wcnt_q  <= '0;
      idx_q   <= '0;
      sreg_q  <= '0;
      rb_q    <= '0;
      rbv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wcnt_q  <= wcnt_d;
      idx_q   <= idx_d;
      sreg_q  <= sreg_d;
      rb_q    <= rb_d;
      rbv_q   <= rbv_d;
    end
  end

  // Next state: fetch a word, shift its valid bits out while capturing the tail, repeat until the chain is full.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wcnt_d    = wcnt_q;
    idx_d     = idx_q;
    sreg_d    = sreg_q;
    rb_d      = rb_q;
    rbv_d     = 1'b0;
    remaining = 32'(CHAIN_LEN) - 32'(cnt_q);

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          cnt_d   = '0;
          state_d = FETCH;
        end
      end
      FETCH: begin
        if (bus.word_valid) begin
          sreg_d = bus.word_in;
          // The last word may be cut short when the chain is not a whole number of words.
          if (remaining > 32'(WORD_W)) begin
            wcnt_d = WCNT_W'(WORD_W);
          end else begin
            wcnt_d = WCNT_W'(remaining);
          end
          idx_d   = '0;
          rb_d    = '0;  // bits beyond a short word read back as 0
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        sreg_d        = sreg_q >> 1;
        rb_d[idx_q]   = bus.ccff_tail;
        idx_d         = idx_q + IDX_W'(1);
        cnt_d         = cnt_q + CNT_W'(1);
        wcnt_d        = wcnt_q - WCNT_W'(1);
        if (wcnt_q == WCNT_W'(1)) begin
          rbv_d   = 1'b1;
          state_d = (cnt_d == CNT_W'(CHAIN_LEN)) ? DONE : FETCH;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs decode the registered state so none of them glitch and all drop with reset.
  assign bus.word_ready     = (state_q == FETCH);
  assign bus.chain_shift_en = (state_q == SHIFT);
  assign bus.ccff_head      = (state_q == SHIFT) & sreg_q[0];
  assign bus.busy           = (state_q != IDLE);
  assign bus.done           = (state_q == DONE);
  assign bus.readback_word  = rb_q;
  assign bus.readback_valid = rbv_q;
endmodule

// File: tb/tb_ccff_chain_loader.sv
// Bench for ccff_chain_loader: two instances (64-bit and 40-bit chains) against a timeline model.
// The model lists the expected per-cycle outputs from word count, stall counts and word bits.
// Tail bits come from a chain model fed by the DUT's own head/shift_en.
module tb_ccff_chain_loader;
  logic clk;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  ccff_chain_loader_if #(.WORD_W(32)) bus0 ();
  ccff_chain_loader_if #(.WORD_W(32)) bus1 ();

  ccff_chain_loader #(.WORD_W(32), .CHAIN_LEN(64)) dut0 (.prog_clk(clk), .prog_reset_n(rst_n), .bus(bus0));
  ccff_chain_loader #(.WORD_W(32), .CHAIN_LEN(40)) dut1 (.prog_clk(clk), .prog_reset_n(rst_n), .bus(bus1));

  logic [1:0]  start_s, valid_s;
  logic [31:0] word_s [2];
  logic [1:0]  o_rdy, o_head, o_sh, o_busy, o_done, o_rbv;
  logic [31:0] o_rbw [2];

  assign bus0.start      = start_s[0];
  assign bus1.start      = start_s[1];
  assign bus0.word_valid = valid_s[0];
  assign bus1.word_valid = valid_s[1];
  assign bus0.word_in    = word_s[0];
  assign bus1.word_in    = word_s[1];
  assign o_rdy[0]  = bus0.word_ready;     assign o_rdy[1]  = bus1.word_ready;
  assign o_head[0] = bus0.ccff_head;      assign o_head[1] = bus1.ccff_head;
  assign o_sh[0]   = bus0.chain_shift_en; assign o_sh[1]   = bus1.chain_shift_en;
  assign o_busy[0] = bus0.busy;           assign o_busy[1] = bus1.busy;
  assign o_done[0] = bus0.done;           assign o_done[1] = bus1.done;
  assign o_rbv[0]  = bus0.readback_valid; assign o_rbv[1]  = bus1.readback_valid;
  assign o_rbw[0]  = bus0.readback_word;
  assign o_rbw[1]  = bus1.readback_word;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Physical chain models: tail is bit 0, head enters at the top bit.
  logic [63:0] chain0;
  logic [39:0] chain1;
  logic [1:0]  pre_req;
  logic [63:0] pre_val;
  assign bus0.ccff_tail = chain0[0];
  assign bus1.ccff_tail = chain1[0];

  always @(posedge clk) begin
    if (pre_req[0]) chain0 <= pre_val;
    else if (o_sh[0]) chain0 <= {o_head[0], chain0[63:1]};
  end
  always @(posedge clk) begin
    if (pre_req[1]) chain1 <= pre_val[39:0];
    else if (o_sh[1]) chain1 <= {o_head[1], chain1[39:1]};
  end

  typedef struct packed {
    logic rdy;
    logic head;
    logic sh;
    logic busy;
    logic done;
    logic rbv;
  } exp_t;

  exp_t        tl [2][512];
  int          tl_len [2];
  int          t [2];
  logic [1:0]  running;
  logic [31:0] rb_exp [2][2];
  logic [31:0] rb_obs [2][2];
  int          rb_seen [2];
  int          sh_cnt [2];
  int          done_t [2];
  logic [31:0] words [2];
  int          stalls [2];

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, req);
    end
  endfunction

  // Expected timeline: idle cycle, then per word (1+stall) fetch cycles and its valid bits, then done.
  task automatic build(input int d, input int L, input logic [63:0] old);
    int          n, w;
    exp_t        e;
    logic [31:0] r;
    n = 0;
    tl[d][n] = '0;
    n++;
    for (int j = 0; j < 2; j++) begin
      w = (L - 32*j < 32) ? L - 32*j : 32;
      for (int k = 0; k <= stalls[j]; k++) begin
        e = '0; e.rdy = 1'b1; e.busy = 1'b1; e.rbv = (j > 0 && k == 0);
        tl[d][n] = e;
        n++;
      end
      r = '0;
      for (int i = 0; i < w; i++) begin
        e = '0; e.sh = 1'b1; e.busy = 1'b1; e.head = words[j][i];
        tl[d][n] = e;
        n++;
        r[i] = old[32*j + i];
      end
      rb_exp[d][j] = r;
    end
    e = '0; e.busy = 1'b1; e.done = 1'b1; e.rbv = 1'b1;
    tl[d][n] = e;
    n++;
    tl_len[d] = n;
  endtask

  // Compare process: every cycle, both DUTs against their timelines (idle when no load is running).
  initial begin
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        exp_t e;
        exp_t a;
        bit   act;
        act = running[d] && (t[d] < tl_len[d]);
        e   = act ? tl[d][t[d]] : '0;
        a   = {o_rdy[d], o_head[d], o_sh[d], o_busy[d], o_done[d], o_rbv[d]};
        chk($sformatf("dut%0d cycle %0d rdy/head/sh/busy/done/rbv", d, t[d]), 64'(a), 64'(e));
        if (act && a.rbv) begin
          if (rb_seen[d] < 2) begin
            rb_obs[d][rb_seen[d]] = o_rbw[d];
            chk($sformatf("dut%0d readback_word %0d", d, rb_seen[d]), 64'(o_rbw[d]), 64'(rb_exp[d][rb_seen[d]]));
          end
          rb_seen[d]++;
        end
        if (act && a.sh)   sh_cnt[d]++;
        if (act && a.done) done_t[d] = t[d];
        if (running[d])    t[d]++;
      end
    end
  end

  task automatic preload(input int d, input logic [63:0] v);
    @(posedge clk); #1;
    pre_val    = v;
    pre_req[d] = 1'b1;
    @(posedge clk); #1;
    pre_req[d] = 1'b0;
  endtask

  task automatic chk_zero(input int d, input string nm);
    chk({nm, " outputs"}, 64'({o_rdy[d], o_head[d], o_sh[d], o_busy[d], o_done[d], o_rbv[d]}), 64'd0);
    chk({nm, " readback_word"}, 64'(o_rbw[d]), 64'd0);
  endtask

  // One load on DUT d; abort>0 pulls reset low during that shift cycle and returns.
  task automatic run(input int d, input int L, input int abort);
    logic [63:0] old, full;
    int          j, stall, nsh;
    bit          hs;
    old = (d == 0) ? chain0 : {24'd0, chain1};
    build(d, L, old);
    @(posedge clk); #1;
    start_s[d] = 1'b1;
    t[d] = 0; rb_seen[d] = 0; sh_cnt[d] = 0; done_t[d] = -1;
    running[d] = 1'b1;
    j = 0; stall = stalls[0]; nsh = 0; hs = 0;
    for (int c = 0; c < tl_len[d] + 2; c++) begin
      @(posedge clk); #1;
      start_s[d] = 1'b0;
      if (hs) begin
        j++;
        hs = 0;
        if (j < 2) stall = stalls[j];
      end
      if (o_rdy[d]) begin
        if (stall > 0) begin
          valid_s[d] = 1'b0;
          word_s[d]  = $urandom;
          stall--;
        end else begin
          valid_s[d] = (j < 2);
          word_s[d]  = words[j % 2];
          hs         = (j < 2);
        end
      end else begin
        valid_s[d] = 1'($urandom_range(0, 1));
        word_s[d]  = $urandom;
        if (o_busy[d] && (abort != 0 || $urandom_range(0, 3) == 0)) start_s[d] = 1'b1;
      end
      if (o_sh[d]) nsh++;
      if (abort != 0 && nsh == abort) begin
        #1;
        rst_n      = 1'b0;
        running[d] = 1'b0;
        #1;
        chk_zero(d, "async reset mid-load");
        start_s[d] = 1'b0;
        valid_s[d] = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        return;
      end
    end
    start_s[d] = 1'b0;
    valid_s[d] = 1'b0;
    running[d] = 1'b0;
    chk($sformatf("dut%0d readback pulses", d), 64'(rb_seen[d]), 64'd2);
    full = {words[1], words[0]};
    if (L < 64) full = full & ((64'd1 << L) - 64'd1);
    chk($sformatf("dut%0d chain after load", d), (d == 0) ? chain0 : {24'd0, chain1}, full);
  endtask

  initial begin
    logic [31:0] tmp;
    start_s = '0; valid_s = '0; word_s[0] = '0; word_s[1] = '0;
    pre_req = '0; pre_val = '0; running = '0;
    for (int d = 0; d < 2; d++) begin
      t[d] = 0; tl_len[d] = 0; rb_seen[d] = 0; sh_cnt[d] = 0; done_t[d] = -1;
    end
    rst_n = 1'b1;
    #3 rst_n = 1'b0;
    #1;
    chk_zero(0, "reset dut0");
    chk_zero(1, "reset dut1");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Full load, valid held high, with known previous configuration.
    preload(0, 64'hDEADBEEF_CAFEF00D);
    words[0] = 32'hA5A5_0F0F; words[1] = 32'h1234_5678;
    stalls[0] = 0; stalls[1] = 0;
    run(0, 64, 0);
    chk("model timeline length", 64'(tl_len[0]), 64'd68);
    chk("model first readback", 64'(rb_exp[0][0]), 64'hCAFE_F00D);
    chk("first readback_word", 64'(rb_obs[0][0]), 64'hCAFE_F00D);
    chk("second readback_word", 64'(rb_obs[0][1]), 64'hDEAD_BEEF);
    chk("shift_en cycles", 64'(sh_cnt[0]), 64'd64);
    chk("done edges after start", 64'(done_t[0] - 1), 64'd66);
    chk("chain holds new words", chain0, 64'h1234_5678_A5A5_0F0F);

    // Backpressure: five idle FETCH cycles before the second word.
    preload(0, {$urandom, $urandom});
    words[0] = $urandom; words[1] = $urandom;
    stalls[0] = 0; stalls[1] = 5;
    run(0, 64, 0);
    chk("done edges with 5-cycle stall", 64'(done_t[0] - 1), 64'd71);

    // Partial last word on the 40-bit chain.
    preload(1, {$urandom, $urandom});
    words[0] = 32'hFFFF_FFFF; words[1] = 32'hFFFF_FFFF;
    stalls[0] = 0; stalls[1] = 0;
    run(1, 40, 0);
    chk("partial shift_en cycles", 64'(sh_cnt[1]), 64'd40);
    tmp = rb_obs[1][1];
    chk("partial readback upper bits", 64'(tmp[31:8]), 64'd0);
    chk("partial done edges", 64'(done_t[1] - 1), 64'd42);
    chk("partial chain", {24'd0, chain1}, 64'h00FF_FFFF_FFFF);

    // Reset during the 10th shift cycle, then a fresh full load.
    words[0] = $urandom; words[1] = $urandom;
    run(0, 64, 10);
    words[0] = $urandom; words[1] = $urandom;
    run(0, 64, 0);
    chk("reload shift_en cycles", 64'(sh_cnt[0]), 64'd64);
    chk("reload done edges", 64'(done_t[0] - 1), 64'd66);

    // Randomised loads on both chain lengths.
    for (int it = 0; it < 8; it++) begin
      int d;
      d = it % 2;
      preload(d, {$urandom, $urandom});
      words[0]  = $urandom;
      words[1]  = $urandom;
      stalls[0] = int'($urandom_range(0, 3));
      stalls[1] = int'($urandom_range(0, 3));
      run(d, (d == 0) ? 64 : 40, 0);
    end

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
